// File: rtl/board_select_ctl.sv
// board_select_ctl: maps the mouse onto the 3x3 board, owns occupancy/ownership,
// turn alternation and win/draw detection for the tic-tac-toe draw stages.
`default_nettype none

module board_select_ctl #(
   parameter logic [11:0] COLOR_P1   = 12'h0F0,
   parameter logic [11:0] COLOR_P2   = 12'h00F,
   parameter logic [11:0] COLOR_BUSY = 12'hF00,
   parameter int          H_EDGE1    = 344,
   parameter int          H_EDGE2    = 680,
   parameter int          V_EDGE1    = 252,
   parameter int          V_EDGE2    = 508
) (
   input  logic        pclk,
   input  logic        rst,
   input  logic [11:0] xpos,
   input  logic [11:0] ypos,
   input  logic        mouse_left,
   input  logic        start_en,
   input  logic        choice_en,
   output logic [8:0]  square,
   output logic [11:0] square_color,
   output logic [8:0]  occupied,
   output logic [8:0]  owner,
   output logic        player,
   output logic        move_done,
   output logic        game_over,
   output logic [1:0]  winner
);

   localparam logic [11:0] HE1   = 12'(H_EDGE1);
   localparam logic [11:0] HE2   = 12'(H_EDGE2);
   localparam logic [11:0] VE1   = 12'(V_EDGE1);
   localparam logic [11:0] VE2   = 12'(V_EDGE2);
   localparam logic [11:0] X_MAX = 12'd1023;
   localparam logic [11:0] Y_MAX = 12'd767;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PLAY  = 2'd1,
      CHECK = 2'd2,
      OVER  = 2'd3
   } state_t;

   state_t      state, state_n;
   logic        mouse_left_d;
   logic        click;
   logic        leave;
   logic [1:0]  col, row;
   logic        on_board;
   logic [3:0]  idx;
   logic [8:0]  hover_oh;
   logic        hover_busy;
   logic [8:0]  mine;
   logic        line_win;
   logic [8:0]  occupied_n, owner_n, square_n;
   logic [11:0] color_n;
   logic        player_n, move_done_n, game_over_n;
   logic [1:0]  winner_n;

   always_comb begin
      col = 2'd2;
      row = 2'd2;
      if (xpos < HE1)      col = 2'd0;
      else if (xpos < HE2) col = 2'd1;
      if (ypos < VE1)      row = 2'd0;
      else if (ypos < VE2) row = 2'd1;
      on_board   = (xpos <= X_MAX) && (ypos <= Y_MAX);
      idx        = ({2'b00, row} * 4'd3) + {2'b00, col};
      hover_oh   = on_board ? (9'd1 << idx) : 9'd0;
      hover_busy = |(hover_oh & occupied);
      click      = mouse_left & ~mouse_left_d;
      leave      = choice_en | ~start_en;
   end

   // Squares held by the side to move; any complete line is a win.
   always_comb begin
      mine     = occupied & (player ? owner : ~owner);
      line_win = (&mine[2:0]) | (&mine[5:3]) | (&mine[8:6])
               | (mine[0] & mine[3] & mine[6])
               | (mine[1] & mine[4] & mine[7])
               | (mine[2] & mine[5] & mine[8])
               | (mine[0] & mine[4] & mine[8])
               | (mine[2] & mine[4] & mine[6]);
   end

   always_comb begin
      state_n     = state;
      occupied_n  = occupied;
      owner_n     = owner;
      player_n    = player;
      game_over_n = game_over;
      winner_n    = winner;
      move_done_n = 1'b0;
      case (state)
         IDLE: begin
            occupied_n  = '0;
            owner_n     = '0;
            player_n    = 1'b0;
            game_over_n = 1'b0;
            winner_n    = 2'b00;
            if (start_en && !choice_en) state_n = PLAY;
         end
         PLAY: begin
            if (leave) begin
               state_n     = IDLE;
               occupied_n  = '0;
               owner_n     = '0;
               player_n    = 1'b0;
               game_over_n = 1'b0;
               winner_n    = 2'b00;
            end else if (click && on_board && !hover_busy) begin
               occupied_n  = occupied | hover_oh;
               owner_n     = player ? (owner | hover_oh) : (owner & ~hover_oh);
               move_done_n = 1'b1;
               state_n     = CHECK;
            end
         end
         CHECK: begin
            if (line_win) begin
               winner_n    = player ? 2'b10 : 2'b01;
               game_over_n = 1'b1;
               state_n     = OVER;
            end else if (&occupied) begin
               winner_n    = 2'b00;
               game_over_n = 1'b1;
               state_n     = OVER;
            end else begin
               player_n = ~player;
               state_n  = PLAY;
            end
         end
         OVER: begin
            if (leave) begin
               state_n     = IDLE;
               occupied_n  = '0;
               owner_n     = '0;
               player_n    = 1'b0;
               game_over_n = 1'b0;
               winner_n    = 2'b00;
            end
         end
         default: state_n = IDLE;
      endcase

      square_n = (state == PLAY) ? hover_oh : 9'd0;
      color_n  = 12'h000;
      if (square_n != 9'd0) color_n = hover_busy ? COLOR_BUSY : (player ? COLOR_P2 : COLOR_P1);
   end

   always_ff @(posedge pclk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_ff @(posedge pclk) begin
      if (rst) begin
         mouse_left_d <= 1'b0;
         square       <= '0;
         square_color <= '0;
         occupied     <= '0;
         owner        <= '0;
         player       <= 1'b0;
         move_done    <= 1'b0;
         game_over    <= 1'b0;
         winner       <= 2'b00;
      end else begin
         mouse_left_d <= mouse_left;
         square       <= square_n;
         square_color <= color_n;
         occupied     <= occupied_n;
         owner        <= owner_n;
         player       <= player_n;
         move_done    <= move_done_n;
         game_over    <= game_over_n;
         winner       <= winner_n;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_board_select_ctl.sv
// Scoreboard bench for board_select_ctl: directed scenarios plus randomized games
// checked against an array-based game model.
`default_nettype none

module tb_board_select_ctl;

   logic        pclk = 1'b0;
   logic        rst, mouse_left, start_en, choice_en;
   logic [11:0] xpos, ypos;
   logic [8:0]  square, occupied, owner;
   logic [11:0] square_color;
   logic        player, move_done, game_over;
   logic [1:0]  winner;

   always #5 pclk = ~pclk;

   board_select_ctl dut (
      .pclk(pclk), .rst(rst), .xpos(xpos), .ypos(ypos), .mouse_left(mouse_left),
      .start_en(start_en), .choice_en(choice_en), .square(square),
      .square_color(square_color), .occupied(occupied), .owner(owner),
      .player(player), .move_done(move_done), .game_over(game_over), .winner(winner)
   );

   typedef struct packed {
      logic [8:0] occ;
      logic [8:0] own;
      logic       pl;
      logic       go;
      logic [1:0] win;
   } exp_t;

   exp_t sbq[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // Game model: cell value 0 empty, 1 player 1, 2 player 2.
   int   mb[9];
   bit   mturn, mplaying, mover;
   int   mwin;
   int   LINES[8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                         '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
   int   CX[3] = '{172, 512, 852};
   int   CY[3] = '{126, 380, 638};

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic int grid(input int v, input int e1, input int e2, input int lim);
      if (v < e1) return 0;
      if (v < e2) return 1;
      if (v <= lim) return 2;
      return -1;
   endfunction

   function automatic int idx_of(input int x, input int y);
      int c, r;
      c = grid(x, 344, 680, 1023);
      r = grid(y, 252, 508, 767);
      if (c < 0 || r < 0) return -1;
      return 3 * r + c;
   endfunction

   function automatic bit model_won(input int p);
      for (int l = 0; l < 8; l++)
         if (mb[LINES[l][0]] == p && mb[LINES[l][1]] == p && mb[LINES[l][2]] == p) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit model_full();
      for (int i = 0; i < 9; i++) if (mb[i] == 0) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic [8:0] occ_vec();
      logic [8:0] v = '0;
      for (int i = 0; i < 9; i++) v[i] = (mb[i] != 0);
      return v;
   endfunction

   function automatic logic [8:0] own_vec();
      logic [8:0] v = '0;
      for (int i = 0; i < 9; i++) v[i] = (mb[i] == 2);
      return v;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 9; i++) mb[i] = 0;
      mturn = 1'b0;
      mover = 1'b0;
      mwin  = 0;
   endtask

   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   task automatic click_at(input int x, input int y, input int hold);
      exp_t e;
      int   k;
      xpos = 12'(x);
      ypos = 12'(y);
      mouse_left = 1'b0;
      tick();
      mouse_left = 1'b1;
      k = idx_of(x, y);
      if (mplaying && !mover && k >= 0 && mb[k] == 0) begin
         mb[k] = int'(mturn) + 1;
         e.occ = occ_vec();
         e.own = own_vec();
         if (model_won(int'(mturn) + 1)) begin
            mover = 1'b1;
            mwin  = int'(mturn) + 1;
         end else if (model_full()) begin
            mover = 1'b1;
            mwin  = 0;
         end else begin
            mturn = ~mturn;
         end
         e.pl  = mturn;
         e.go  = mover;
         e.win = 2'(mwin);
         sbq.push_back(e);
      end
      repeat (hold) tick();
      mouse_left = 1'b0;
      tick();
   endtask

   task automatic hover_chk(input int x, input int y);
      int          k;
      logic [8:0]  es;
      logic [11:0] ec;
      xpos = 12'(x);
      ypos = 12'(y);
      mouse_left = 1'b0;
      @(posedge pclk);
      @(negedge pclk);
      k  = idx_of(x, y);
      es = '0;
      ec = '0;
      if (mplaying && !mover && k >= 0) begin
         es = 9'(1 << k);
         ec = (mb[k] != 0) ? 12'hF00 : (mturn ? 12'h00F : 12'h0F0);
      end
      chk($sformatf("square(%0d,%0d)", x, y), 32'(square), 32'(es));
      chk($sformatf("square_color(%0d,%0d)", x, y), 32'(square_color), 32'(ec));
   endtask

   task automatic chk_board(input string tag);
      chk({tag, "_occupied"}, 32'(occupied), 32'(occ_vec()));
      chk({tag, "_owner"}, 32'(owner & occupied), 32'(own_vec()));
      chk({tag, "_game_over"}, 32'(game_over), 32'(mover));
      chk({tag, "_winner"}, 32'(winner), 32'(mover ? mwin : 0));
   endtask

   task automatic start_game();
      start_en  = 1'b1;
      choice_en = 1'b0;
      tick();
      mplaying = 1'b1;
   endtask

   task automatic leave_game();
      start_en = 1'b0;
      tick();
      mplaying = 1'b0;
      model_clear();
      tick();
      chk_board("after_leave");
   endtask

   task automatic click_sq(input int s);
      click_at(CX[s % 3], CY[s / 3], 2);
   endtask

   // Monitor: each move_done pulse retires one scoreboard entry.
   initial begin
      exp_t e;
      forever begin
         @(negedge pclk);
         if (move_done === 1'b1) begin
            if (sbq.size() == 0) begin
               chk("move_done_unexpected", 32'(move_done), 32'd0);
            end else begin
               e = sbq.pop_front();
               chk("mv_occupied", 32'(occupied), 32'(e.occ));
               chk("mv_owner", 32'(owner & occupied), 32'(e.own));
               @(negedge pclk);
               chk("move_done_width", 32'(move_done), 32'd0);
               chk("mv_player", 32'(player), 32'(e.pl));
               chk("mv_game_over", 32'(game_over), 32'(e.go));
               chk("mv_winner", 32'(winner), 32'(e.win));
            end
         end
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int xs[6] = '{343, 344, 679, 680, 1023, 1024};
      int ys[6] = '{251, 252, 507, 508, 767, 768};
      int draw_seq[9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
      int win_seq[5]  = '{0, 3, 1, 4, 2};

      rst = 1'b1; start_en = 1'b0; choice_en = 1'b0; mouse_left = 1'b0;
      xpos = 12'd0; ypos = 12'd0; mplaying = 1'b0;
      model_clear();
      repeat (2) tick();
      chk("rst_square", 32'(square), 32'd0);
      chk("rst_color", 32'(square_color), 32'd0);
      chk("rst_player", 32'(player), 32'd0);
      chk("rst_move_done", 32'(move_done), 32'd0);
      chk_board("rst");
      rst = 1'b0;
      hover_chk(400, 100);

      // First move and re-click of the same square.
      start_game();
      hover_chk(400, 100);
      chk("start_player", 32'(player), 32'd0);
      click_at(400, 100, 5);
      hover_chk(400, 100);
      click_at(400, 100, 3);
      chk_board("reclick");
      leave_game();

      // Player 1 wins along the top row.
      start_game();
      foreach (win_seq[i]) click_sq(win_seq[i]);
      hover_chk(CX[2], CY[2]);
      click_sq(8);
      chk_board("win");
      choice_en = 1'b1;
      leave_game();

      // Full board without a line.
      start_game();
      foreach (draw_seq[i]) click_sq(draw_seq[i]);
      chk_board("draw");
      chk("draw_full", 32'(occupied), 32'h1FF);
      leave_game();

      // Off-board clicks and boundary decode.
      start_game();
      click_at(1100, 100, 2);
      click_at(400, 800, 2);
      hover_chk(1100, 100);
      hover_chk(400, 800);
      foreach (xs[i]) hover_chk(xs[i], 100);
      foreach (ys[i]) hover_chk(100, ys[i]);
      chk_board("offboard");

      // Leaving the game beats a click in the same cycle.
      click_sq(0);
      xpos = 12'(CX[1]); ypos = 12'(CY[1]); mouse_left = 1'b0;
      tick();
      mouse_left = 1'b1;
      choice_en  = 1'b1;
      tick();
      mplaying = 1'b0;
      model_clear();
      mouse_left = 1'b0;
      tick();
      chk_board("leave_click");
      hover_chk(CX[1], CY[1]);
      choice_en = 1'b0;
      start_en  = 1'b0;
      tick();

      // Reset mid-game with four squares taken.
      start_game();
      for (int i = 0; i < 4; i++) click_sq(i * 2);
      chk_board("pre_rst");
      rst = 1'b1;
      start_en = 1'b0;
      tick();
      mplaying = 1'b0;
      model_clear();
      chk("midrst_square", 32'(square), 32'd0);
      chk("midrst_color", 32'(square_color), 32'd0);
      chk("midrst_player", 32'(player), 32'd0);
      chk("midrst_move_done", 32'(move_done), 32'd0);
      chk_board("midrst");
      rst = 1'b0;
      hover_chk(CX[1], CY[1]);
      start_game();
      hover_chk(CX[1], CY[1]);
      leave_game();

      // Randomized games: mostly square centres, some arbitrary coordinates.
      for (int g = 0; g < 6; g++) begin
         start_game();
         for (int c = 0; c < 30; c++) begin
            if ($urandom_range(0, 9) < 7) begin
               int s = int'($urandom_range(0, 8));
               click_at(CX[s % 3], CY[s / 3], int'($urandom_range(1, 4)));
            end else begin
               click_at(int'($urandom_range(0, 1150)), int'($urandom_range(0, 850)),
                        int'($urandom_range(1, 4)));
            end
            if ($urandom_range(0, 3) == 0)
               hover_chk(int'($urandom_range(0, 1100)), int'($urandom_range(0, 820)));
         end
         chk_board($sformatf("rand%0d", g));
         leave_game();
      end

      repeat (10) tick();
      chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/board_select_ctl.md
Name: board_select_ctl

Overview:
- Upstream control stage for the per-square draw stages (square1..square9 overlays) in the tic-tac-toe video pipeline.
- Maps the mouse position onto the 3x3 board and drives the one-hot hover flags and the highlight colour those draw stages consume.
- Owns the board occupancy and ownership registers, the turn alternation and win/draw detection.
- Its outputs are registered on pclk and fed straight to the draw stages and to the X/O mark renderer.

Parameters:
- COLOR_P1, 12'h0F0, highlight colour when player 1 is to move.
- COLOR_P2, 12'h00F, highlight colour when player 2 is to move.
- COLOR_BUSY, 12'hF00, highlight colour when the hovered square is already occupied.
- H_EDGE1, 344, first x of column 1 (column 0 = 0..H_EDGE1-1).
- H_EDGE2, 680, first x of column 2 (column 2 ends at 1023).
- V_EDGE1, 252, first y of row 1 (row 0 = 0..V_EDGE1-1).
- V_EDGE2, 508, first y of row 2 (row 2 ends at 767).

Ports:
- pclk  in  1  pixel clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- xpos  in  12  mouse x, pclk domain.
- ypos  in  12  mouse y, pclk domain.
- mouse_left  in  1  left button level, pclk domain.
- start_en  in  1  game started (from menu).
- choice_en  in  1  menu/choice screen active; blocks play.
- square  out  9  one-hot hover flag; bit i = square i (row-major, i = 3*row+col; bit 1 = square2).
- square_color  out  12  colour applied by the draw stages to the hovered square.
- occupied  out  9  square i taken.
- owner  out  9  owner of square i (0 = P1, 1 = P2); valid only where occupied=1.
- player  out  1  side to move (0 = P1).
- move_done  out  1  one-cycle pulse when a move is accepted.
- game_over  out  1  game finished.
- winner  out  2  00 none/draw, 01 P1, 10 P2; valid when game_over=1.

Behaviour:
Reset (rst=1 at a clock edge):
- All outputs and state go to 0, state = IDLE, and the button edge register = 0.
- Reset applies in any state, including mid-game, and clears the board.

Hover decode:
- Combinational from xpos/ypos:
  - col = 0 if x < H_EDGE1, 1 if x < H_EDGE2, 2 if x <= 1023.
  - Rows decode the same way using V_EDGE1, V_EDGE2 and 767.
  - x > 1023 or y > 767 means off-board, with no hover.
- square is registered, so 1-cycle latency from xpos/ypos.
- square = 0 when off-board or state != PLAY.
- square_color is registered alongside square:
  - COLOR_BUSY if the hovered square is occupied;
  - else COLOR_P1 or COLOR_P2 according to player;
  - 0 when square = 0.

Click:
- click = mouse_left & ~mouse_left_d, where mouse_left_d is mouse_left registered.
- A held button produces exactly one click.

FSM:
- IDLE:
  - Board, player, winner and game_over are held at 0.
  - Go to PLAY when start_en=1 and choice_en=0.
- PLAY:
  - If choice_en=1 or start_en=0, go to IDLE (board cleared).
  - On a click with on-board hover index k and occupied[k]=0:
    - set occupied[k]=1 and owner[k]=player;
    - pulse move_done in the same edge;
    - go to CHECK.
  - A click on an occupied square or off-board is ignored, with no pulse.
- CHECK (exactly 1 cycle):
  - Evaluate the 8 lines (3 rows, 3 columns, 2 diagonals) for the current player.
  - Win: winner = player+1, game_over=1, go to OVER.
  - Else, all 9 occupied: winner=00, game_over=1, go to OVER.
  - Else: toggle player and return to PLAY.
  - Clicks in CHECK are ignored.
- OVER:
  - Board frozen, square=0, clicks ignored.
  - When start_en=0 or choice_en=1, go to IDLE (which clears everything).

Simultaneous events:
- The leave condition (choice_en/start_en) beats a click in PLAY; the move is not recorded.
- rst beats everything.

Move timing:
- Player toggle happens 2 cycles after the accepted click edge.
- The board update is visible 1 cycle after the click edge.

Test Plan:
- Reset, then start_en=1, choice_en=0, xpos=400, ypos=100 -> 1 cycle later square=9'b000000010, square_color=12'h0F0, player=0.
- Click (mouse_left 0->1, held 5 cycles) at (400,100) -> occupied=9'h002, owner=0, one move_done pulse; 2 cycles later player=1. Re-click same square -> no change, square_color=12'hF00.
- P1 at squares 0,1,2 with P2 at 3,4 (alternating clicks at centres) -> after P1's third move, game_over=1, winner=01, square=0, further clicks ignored.
- Fill the board with no line (P1: 0,2,3,7,8; P2: 1,4,5,6 in alternation) -> game_over=1, winner=00, occupied=9'h1FF.
- xpos=1100 or ypos=800 with click -> square=0, no move_done. choice_en=1 in the same cycle as a valid click -> no move recorded, state IDLE, board=0.
- rst pulsed mid-game with 4 squares occupied -> next cycle all outputs 0; game restarts only when start_en=1 and choice_en=0.
